hazard_forward_ctrl: RTL

Combined operand-forwarding and load-use hazard controller for the 5-stage pipeline, sitting between ID/EX/MEM/WB pipeline registers and the ALU operand muxes / PC and IF-ID enables.
- Successor to the single-condition forward unit: independent per-operand forwarding with MEM-over-WB priority and x0 exclusion.
- Adds a load-use stall FSM with parametrised load latency, flush override and a saturating stall-cycle performance counter.

---
 rtl/hazard_forward_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Operand-forwarding and load-use hazard controller for a 5-stage pipeline.
// It sits between the ID/EX/MEM/WB pipeline registers and the ALU operand
// muxes, the PC enable and the IF/ID enable.
//
// Forwarding (purely combinational, one independent path per ALU operand):
//   10 = take the MEM-stage ALU result, 01 = take the WB write data,
//   00 = use the register-file read. MEM has priority over WB. A destination
//   of x0 never forwards. A load sitting in MEM never forwards from MEM,
//   because the stall logic makes sure its data arrives through WB instead.
//
// Load-use stall: when the instruction in EX is a load whose rd is read by
// the instruction in ID, PC and IF/ID are held and a bubble enters ID/EX for
// exactly LOAD_LAT cycles. The first stall cycle is asserted combinationally
// in the same cycle the hazard is seen. A flush (taken branch/jump) overrides
// everything: the stall is dropped and only the bubble is kept.
//
// stall_cycles is a saturating count of cycles in which IF/ID was held.
//
// Parameters:
//   ADDR_W   register-address width
//   LOAD_LAT stall cycles per load-use hazard, legal range 1..15
//   CNT_W    width of the stall-cycle counter
//
// Ports:
//   clk, arst_n                      clock (rising edge), async active-low reset
//   rs1_id, rs2_id, use_rs1/2_id     sources of the instruction in ID
//   rs1_ex, rs2_ex, rd_ex            sources/destination of the instruction in EX
//   reg_write_ex, mem_read_ex        EX writes rd / EX is a load
//   rd_mem, reg_write_mem, mem_read_mem   MEM destination / write / is-load
//   rd_wb, reg_write_wb              WB destination / write
//   flush                            squash IF/ID (branch/jump resolved)
//   mux_alu_1, mux_alu_2             operand select per operand
//   stall_pc, stall_ifid, bubble_ex  pipeline hold / bubble controls
//   stall_cycles                     saturating stalled-cycle count
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [ADDR_W-1:0] rs1_id,
    input  logic [ADDR_W-1:0] rs2_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic [ADDR_W-1:0] rs1_ex,
    input  logic [ADDR_W-1:0] rs2_ex,
    input  logic [ADDR_W-1:0] rd_ex,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic [ADDR_W-1:0] rd_mem,
    input  logic              reg_write_mem,
    input  logic              mem_read_mem,
    input  logic [ADDR_W-1:0] rd_wb,
    input  logic              reg_write_wb,
    input  logic              flush,
    output logic [1:0]        mux_alu_1,
    output logic [1:0]        mux_alu_2,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_ex,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Operand select encodings
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    // FSM state encodings
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // Cycles still to be spent in STALL after the first (Mealy) stall cycle
    localparam logic [3:0] LAT_REMAIN = 4'(LOAD_LAT - 1);

    // -------------------------------------------------------------------------
    // Forwarding: one identical path per operand
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] rs_ex_arr [2];
    logic [1:0]        fwd_sel   [2];

    assign rs_ex_arr[0] = rs1_ex;
    assign rs_ex_arr[1] = rs2_ex;

    // The MEM-stage value of a load is the address, not the data, so a load in
    // MEM is excluded from the MEM path; the stall has already delayed the
    // consumer far enough that the loaded data is caught from WB.
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    assign mem_fwd_ok = reg_write_mem && !mem_read_mem && (rd_mem != '0);
    assign wb_fwd_ok  = reg_write_wb && (rd_wb != '0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit;
            logic wb_hit;

            assign mem_hit = mem_fwd_ok && (rd_mem == rs_ex_arr[gi]);
            assign wb_hit  = wb_fwd_ok  && (rd_wb  == rs_ex_arr[gi]);

            always_comb begin
                fwd_sel[gi] = SEL_RF;
                if (mem_hit) begin
                    fwd_sel[gi] = SEL_MEM;
                end else if (wb_hit) begin
                    fwd_sel[gi] = SEL_WB;
                end
            end
        end
    endgenerate

    // Selects are forced to the register file while reset is held
    assign mux_alu_1 = arst_n ? fwd_sel[0] : SEL_RF;
    assign mux_alu_2 = arst_n ? fwd_sel[1] : SEL_RF;

    // -------------------------------------------------------------------------
    // Load-use hazard detection
    // -------------------------------------------------------------------------
    logic rs1_dep;
    logic rs2_dep;
    logic load_use_hz;

    assign rs1_dep     = use_rs1_id && (rs1_id == rd_ex);
    assign rs2_dep     = use_rs2_id && (rs2_id == rd_ex);
    assign load_use_hz = mem_read_ex && reg_write_ex && (rd_ex != '0)
                         && (rs1_dep || rs2_dep);

    // -------------------------------------------------------------------------
    // Stall FSM
    //   RUN  : watch for a hazard; the first stall cycle is issued here.
    //   STALL: hold for the remaining LOAD_LAT-1 cycles; hazards are not
    //          re-examined here because the same load is still in flight.
    // -------------------------------------------------------------------------
    logic [0:0] state_reg;
    logic [0:0] state_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic       stall_raw;
    logic       bubble_raw;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_raw  = 1'b0;
        bubble_raw = 1'b0;

        if (flush) begin
            // The dependent instruction is being squashed: abandon any stall,
            // but still keep garbage out of ID/EX.
            state_next = ST_RUN;
            cnt_next   = 4'd0;
            bubble_raw = 1'b1;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (load_use_hz) begin
                        stall_raw  = 1'b1;
                        bubble_raw = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_next = ST_STALL;
                            cnt_next   = LAT_REMAIN;
                        end
                    end
                end
                ST_STALL: begin
                    stall_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    // cnt counts the stall cycles still owed including this
                    // one; a value of 0 cannot occur here but is treated as
                    // the last cycle so the FSM can never lock up.
                    if (cnt_reg <= 4'd1) begin
                        state_next = ST_RUN;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = 4'(cnt_reg - 4'd1);
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign stall_pc   = arst_n && stall_raw;
    assign stall_ifid = arst_n && stall_raw;
    assign bubble_ex  = arst_n && bubble_raw;

    // -------------------------------------------------------------------------
    // Saturating stall-cycle counter
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_raw && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cycles = stall_cnt_reg;

endmodule
